seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Display-side reader for the four 7-segment codes and `drop_activated` flag produced by the drop/display logic.
- Latches a new frame on a load strobe and time-multiplexes the four digits onto one shared segment bus with active-low digit enables.
- Inserts an anti-ghosting blank window before each digit, applies 4-bit PWM brightness, and blinks a drop LED while a drop is active.

Parameters:
- CLK_PER_DIGIT, 1000, clock cycles per digit slot; must be > BLANK_CYCLES+16.
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits off.
- BLINK_FRAMES, 64, full frames per drop_led toggle.
- BLANK_PAT, 7'b0000000, seg_out value while no digit is enabled.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_in1..seg_in4  in  7 each  segment codes for digits 0..3; bits pass through unchanged
- drop_in  in  1  drop_activated flag from the display logic
- load  in  1  one-cycle strobe; capture seg_in1..4 and drop_in
- brightness  in  4  0 = dimmest, 15 = full on-window
- seg_out  out  7  shared segment bus
- digit_an  out  4  active-low digit enables; bit i = digit i
- drop_led  out  1  drop indicator
- frame_done  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset (async, rst_n=0) forces immediately: seg_out=BLANK_PAT, digit_an=4'b1111, drop_led=0, frame_done=0. All counters, pending/active registers and bright_act are cleared to 0, and the FSM goes to BLANK.
- After reset release, the scan starts at digit 0, slot_cnt 0.
- Capture:
  - load=1 at a clk edge writes seg_in1..4 and drop_in into the pending registers and sets pend_valid.
  - A later load before the frame boundary overwrites pending; last load wins.
- Frame boundary is the cycle with digit_idx=0 and slot_cnt=0. At that edge:
  - if pend_valid, the active registers take pending and pend_valid clears;
  - if load=1 in the same cycle, active takes seg_in*/drop_in directly (bypass) and pend_valid stays 0;
  - brightness is sampled into bright_act.
- Counters:
  - slot_cnt counts 0..CLK_PER_DIGIT-1, then wraps.
  - On wrap, digit_idx goes 0→1→2→3→0.
  - frame_cnt (for blink) increments on each frame_done.
- on_len = ((CLK_PER_DIGIT-BLANK_CYCLES)*(bright_act+1))>>4. Compute the multiply at full width; no truncation before the shift.
- FSM, per slot:
  - BLANK: slot_cnt < BLANK_CYCLES.
  - ON: BLANK_CYCLES <= slot_cnt < BLANK_CYCLES+on_len.
  - OFF: the remainder of the slot.
  - Transitions are BLANK→ON→OFF→BLANK (next digit). OFF is skipped when on_len fills the window (brightness 15).
- Outputs are registered and reflect the state of the previous cycle (1-cycle latency):
  - ON: digit_an has only bit digit_idx low; seg_out = active code of digit_idx.
  - BLANK or OFF: digit_an=4'b1111, seg_out=BLANK_PAT.
  - Never more than one digit_an bit is low in any cycle.
- frame_done: high for exactly the one cycle after the cycle with digit_idx=3 and slot_cnt=CLK_PER_DIGIT-1.
- drop_led:
  - Active drop flag 0: drop_led=0 and frame_cnt is held at 0.
  - Active drop flag 1: drop_led toggles each time frame_cnt reaches BLINK_FRAMES-1, and frame_cnt then wraps to 0.
  - On a 0→1 change of the active flag, drop_led turns on at the next frame boundary.
- Reset asserted mid-slot or mid-frame: outputs go off immediately. Pending data is lost; the scan restarts from digit 0.

Decomposition:
- Shared package (disp_pkg):
  - FSM state encoding (BLANK/ON/OFF);
  - DIGITS=4 and SEG_W=7 constants;
  - all-digits-off constant 4'b1111.
- One sub-module, pwm_window: slot counter plus BLANK/ON/OFF FSM. Inputs are on_len and enable; outputs are the state and a slot-wrap pulse.
- The top level holds capture/active registers, digit index, muxing and blink logic.

Test Plan:
All tests use CLK_PER_DIGIT=40, BLANK_CYCLES=8, BLINK_FRAMES=2, BLANK_PAT=0.
1. Reset with no load → digit_an=4'b1111 and seg_out=0 throughout. After the first load of codes 7'h3F,7'h06,7'h5B,7'h4F with brightness=15, the next frame shows each digit for 32 cycles after 8 blank cycles, in the order an=1110,1101,1011,0111. frame_done pulses every 160 cycles.
2. brightness=3 → on_len=8. Each digit is enabled for 8 cycles, then off for 24. A change to brightness=0 mid-frame → on_len=2, applied from the next frame only.
3. Load A mid-frame, then load B before the boundary → the next frame shows B. Load C exactly on a boundary cycle → C is displayed in that same frame (bypass).
4. drop_in=1 loaded → drop_led=1 at the next boundary and toggles every 2 frames (320 cycles). Loading drop_in=0 → drop_led=0 at the following boundary.
5. rst_n pulled low mid-ON of digit 2 → same-cycle digit_an=4'b1111, seg_out=0, drop_led=0. After release: no digit enabled until a new load; scan restarts at digit 0.
6. Random loads and brightness values for 10k cycles → assert at most one digit_an bit low per cycle, and seg_out=BLANK_PAT whenever digit_an=4'b1111.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
package disp_pkg;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned SEG_W     = 7;
  localparam int unsigned DIG_IDX_W = 2;

  localparam logic [DIGITS-1:0] AN_ALL_OFF = 4'b1111;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2
  } win_state_t;

  // One displayable frame: digit i lives in seg[i]
  typedef struct packed {
    logic                         drop;
    logic [DIGITS-1:0][SEG_W-1:0] seg;
  } frame_t;

  // Active-low enable pattern with only the selected digit driven
  function automatic logic [DIGITS-1:0] digit_enable(input logic [DIG_IDX_W-1:0] idx);
    return ~(DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scanner_pwm_window.sv
// Per-digit slot timer: counts the slot and walks BLANK -> ON -> OFF within it.
module pwm_window
  import disp_pkg::*;
#(
  parameter  int unsigned CLK_PER_DIGIT = 1000,
  parameter  int unsigned BLANK_CYCLES  = 16,
  localparam int unsigned CNT_W         = $clog2(CLK_PER_DIGIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] on_len,
  output win_state_t       state,
  output logic             slot_wrap_c
);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   on_end;
  win_state_t       state_nxt;

  assign slot_wrap_c = (slot_cnt == SLOT_LAST);
  assign cnt_nxt     = slot_wrap_c ? '0 : slot_cnt + CNT_W'(1);
  assign on_end      = {1'b0, BLANK_END} + {1'b0, on_len};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      state    <= ST_BLANK;
    end else begin
      slot_cnt <= cnt_nxt;
      state    <= state_nxt;
    end
  end

  // State for the coming cycle is decided from the slot position it will hold
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BLANK: begin
        if (cnt_nxt == BLANK_END) begin
          state_nxt = enable ? ST_ON : ST_OFF;
        end
      end
      ST_ON: begin
        // a full-width window reaches the wrap before on_end, so OFF is skipped
        if (slot_wrap_c) begin
          state_nxt = ST_BLANK;
        end else if ({1'b0, cnt_nxt} == on_end) begin
          state_nxt = ST_OFF;
        end
      end
      ST_OFF: begin
        if (slot_wrap_c) begin
          state_nxt = ST_BLANK;
        end
      end
      default: state_nxt = ST_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Frame capture, digit multiplexing, PWM brightness and drop-LED blink for a
// four-digit common-bus 7-segment display.
module seven_seg_scanner
  import disp_pkg::*;
#(
  parameter int unsigned      CLK_PER_DIGIT = 1000,
  parameter int unsigned      BLANK_CYCLES  = 16,
  parameter int unsigned      BLINK_FRAMES  = 64,
  parameter logic [SEG_W-1:0] BLANK_PAT     = 7'b0000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEG_W-1:0]  seg_in1,
  input  logic [SEG_W-1:0]  seg_in2,
  input  logic [SEG_W-1:0]  seg_in3,
  input  logic [SEG_W-1:0]  seg_in4,
  input  logic              drop_in,
  input  logic              load,
  input  logic [3:0]        brightness,
  output logic [SEG_W-1:0]  seg_out,
  output logic [DIGITS-1:0] digit_an,
  output logic              drop_led,
  output logic              frame_done
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_DIGIT);
  localparam int unsigned ON_W  = CNT_W + 5;
  localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [ON_W-1:0]      WIN_LEN   = ON_W'(CLK_PER_DIGIT - BLANK_CYCLES);
  localparam logic [FC_W-1:0]      FC_LAST   = FC_W'(BLINK_FRAMES - 1);
  localparam logic [DIG_IDX_W-1:0] DIG_LAST  = DIG_IDX_W'(DIGITS - 1);

  frame_t               in_frame;
  frame_t               pend;
  frame_t               act;
  logic                 pend_valid;
  logic                 act_valid;
  logic [3:0]           bright_act;
  logic [DIG_IDX_W-1:0] digit_idx;
  logic                 slot_first;
  logic [FC_W-1:0]      frame_cnt;
  logic [ON_W-1:0]      on_prod;
  logic [CNT_W-1:0]     on_len;
  logic                 boundary_c;
  logic                 drop_nxt;
  logic                 slot_wrap_c;
  win_state_t           win_state;

  assign in_frame.drop = drop_in;
  assign in_frame.seg  = {seg_in4, seg_in3, seg_in2, seg_in1};

  // Full-width product keeps every bit until the divide-by-16
  assign on_prod = WIN_LEN * (ON_W'(bright_act) + ON_W'(1));
  assign on_len  = CNT_W'(on_prod >> 4);

  assign boundary_c = slot_first && (digit_idx == '0);

  pwm_window #(
    .CLK_PER_DIGIT(CLK_PER_DIGIT),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (act_valid),
    .on_len     (on_len),
    .state      (win_state),
    .slot_wrap_c(slot_wrap_c)
  );

  // Digit scan position; slot_first marks slot_cnt == 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx  <= '0;
      slot_first <= 1'b1;
    end else begin
      slot_first <= slot_wrap_c;
      if (slot_wrap_c) begin
        digit_idx <= digit_idx + DIG_IDX_W'(1);
      end
    end
  end

  // Pending/active frame capture; a load on the boundary goes straight to active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      pend_valid <= 1'b0;
      act        <= '0;
      act_valid  <= 1'b0;
      bright_act <= '0;
    end else if (boundary_c) begin
      pend_valid <= 1'b0;
      bright_act <= brightness;
      if (load) begin
        act       <= in_frame;
        act_valid <= 1'b1;
      end else if (pend_valid) begin
        act       <= pend;
        act_valid <= 1'b1;
      end
    end else if (load) begin
      pend       <= in_frame;
      pend_valid <= 1'b1;
    end
  end

  // Drop flag as it will read after this edge
  always_comb begin
    drop_nxt = act.drop;
    if (boundary_c) begin
      if (load) begin
        drop_nxt = drop_in;
      end else if (pend_valid) begin
        drop_nxt = pend.drop;
      end
    end
  end

  // Blink: lit on activation, then toggles every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_led  <= 1'b0;
      frame_cnt <= '0;
    end else if (boundary_c) begin
      if (!drop_nxt) begin
        drop_led  <= 1'b0;
        frame_cnt <= '0;
      end else if (!act.drop) begin
        drop_led  <= 1'b1;
        frame_cnt <= '0;
      end else if (frame_done) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt <= '0;
          drop_led  <= ~drop_led;
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end
    end
  end

  // Segment bus and digit enables, one cycle behind the window state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= BLANK_PAT;
      digit_an   <= AN_ALL_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= slot_wrap_c && (digit_idx == DIG_LAST);
      if (win_state == ST_ON) begin
        digit_an <= digit_enable(digit_idx);
        seg_out  <= act.seg[digit_idx];
      end else begin
        digit_an <= AN_ALL_OFF;
        seg_out  <= BLANK_PAT;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: frame-position reference model plus directed pins.
module tb_seven_seg_scanner;

  localparam int CPD   = 40;
  localparam int BLK   = 8;
  localparam int BF    = 2;
  localparam int FRAME = 4 * CPD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic       drop_in = 1'b0;
  logic [6:0] seg_in1 = '0;
  logic [6:0] seg_in2 = '0;
  logic [6:0] seg_in3 = '0;
  logic [6:0] seg_in4 = '0;
  logic [3:0] brightness = '0;
  logic [6:0] seg_out;
  logic [3:0] digit_an;
  logic       drop_led;
  logic       frame_done;

  int total = 0;
  int bad = 0;

  seven_seg_scanner #(
    .CLK_PER_DIGIT(CPD),
    .BLANK_CYCLES (BLK),
    .BLINK_FRAMES (BF),
    .BLANK_PAT    (7'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in1   (seg_in1),
    .seg_in2   (seg_in2),
    .seg_in3   (seg_in3),
    .seg_in4   (seg_in4),
    .drop_in   (drop_in),
    .load      (load),
    .brightness(brightness),
    .seg_out   (seg_out),
    .digit_an  (digit_an),
    .drop_led  (drop_led),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Reference model: position within the frame decides everything
  int         pos = 0;
  int         fr = 0;
  int         f0 = 0;
  int         b_act = 0;
  int         s_m = 0;
  int         onl = 0;
  logic [1:0] d_m = '0;
  bit         a_valid = 0;
  bit         a_drop = 0;
  bit         p_valid = 0;
  bit         p_drop = 0;
  bit         old_drop = 0;
  logic [6:0] a_code [4] = '{default: '0};
  logic [6:0] p_code [4] = '{default: '0};
  logic [6:0] e_seg = '0;
  logic [3:0] e_an = 4'hF;
  bit         e_led = 0;
  bit         e_fd = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pos = 0; fr = 0; f0 = 0; b_act = 0;
      a_valid = 0; a_drop = 0; p_valid = 0; p_drop = 0;
      for (int i = 0; i < 4; i++) begin
        a_code[i] = '0;
        p_code[i] = '0;
      end
      e_seg = '0; e_an = 4'hF; e_led = 0; e_fd = 0;
    end else begin
      s_m = pos % CPD;
      d_m = 2'(pos / CPD);
      onl = ((CPD - BLK) * (b_act + 1)) / 16;
      e_an = 4'hF;
      e_seg = '0;
      if (a_valid && s_m >= BLK && s_m < BLK + onl) begin
        e_an[d_m] = 1'b0;
        e_seg = a_code[d_m];
      end
      e_fd = (pos == FRAME - 1);
      if (pos == 0) begin
        old_drop = a_drop;
        if (load) begin
          a_code[0] = seg_in1; a_code[1] = seg_in2; a_code[2] = seg_in3; a_code[3] = seg_in4;
          a_drop = drop_in; a_valid = 1; p_valid = 0;
        end else if (p_valid) begin
          a_code = p_code; a_drop = p_drop; a_valid = 1; p_valid = 0;
        end
        b_act = int'(brightness);
        if (a_drop && !old_drop) f0 = fr;
        e_led = a_drop && ((((fr - f0) / BF) % 2) == 0);
        fr++;
      end else if (load) begin
        p_code[0] = seg_in1; p_code[1] = seg_in2; p_code[2] = seg_in3; p_code[3] = seg_in4;
        p_drop = drop_in; p_valid = 1;
      end
      pos = (pos + 1) % FRAME;
    end
  end

  // Per-cycle compare against the model plus bus invariants
  initial forever begin
    @(negedge clk);
    check("seg_out", 32'(seg_out), 32'(e_seg));
    check("digit_an", 32'(digit_an), 32'(e_an));
    check("drop_led", 32'(drop_led), 32'(e_led));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("one_digit", 32'($countones(~digit_an) <= 1), 32'(1));
    check("blank_pat", 32'((digit_an != 4'hF) || (seg_out == 7'h00)), 32'(1));
  end

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pos != p && n < 2 * FRAME);
    if (pos != p) begin
      total++;
      bad++;
      $display("FAIL wait_pos: got %0d want %0d", pos, p);
    end
  endtask

  task automatic do_load(input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                         input logic [6:0] c3, input logic d);
    seg_in1 = c0; seg_in2 = c1; seg_in3 = c2; seg_in4 = c3; drop_in = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_an", 32'(digit_an), 32'hF);
    check("rst_seg", 32'(seg_out), 32'h0);
    check("rst_led", 32'(drop_led), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    rst_n = 1'b1;

    // 1: idle until loaded, then full-brightness scan order
    wait_pos(9);
    check("t1_idle_an", 32'(digit_an), 32'hF);
    wait_pos(50);
    brightness = 4'd15;
    do_load(7'h3F, 7'h06, 7'h5B, 7'h4F, 1'b0);
    wait_pos(8);   check("t1_blank_an", 32'(digit_an), 32'hF);
    wait_pos(9);   check("t1_d0_an", 32'(digit_an), 32'hE);
                   check("t1_d0_seg", 32'(seg_out), 32'h3F);
    wait_pos(40);  check("t1_d0_last", 32'(digit_an), 32'hE);
    wait_pos(41);  check("t1_d0_off", 32'(digit_an), 32'hF);
    wait_pos(49);  check("t1_d1_an", 32'(digit_an), 32'hD);
                   check("t1_d1_seg", 32'(seg_out), 32'h06);
    wait_pos(129); check("t1_d3_an", 32'(digit_an), 32'h7);
                   check("t1_d3_seg", 32'(seg_out), 32'h4F);
    wait_pos(0);   check("t1_fd_hi", 32'(frame_done), 32'h1);
    wait_pos(1);   check("t1_fd_lo", 32'(frame_done), 32'h0);

    // 2: brightness 3 then 0, applied at frame boundaries only
    brightness = 4'd3;
    wait_pos(0);
    wait_pos(16);  check("t2_b3_on", 32'(digit_an), 32'hE);
    wait_pos(17);  check("t2_b3_off", 32'(digit_an), 32'hF);
    wait_pos(60);
    brightness = 4'd0;
    wait_pos(95);  check("t2_d2_on", 32'(digit_an), 32'hB);
                   check("t2_d2_seg", 32'(seg_out), 32'h5B);
    wait_pos(97);  check("t2_d2_off", 32'(digit_an), 32'hF);
    wait_pos(10);  check("t2_b0_on", 32'(digit_an), 32'hE);
    wait_pos(11);  check("t2_b0_off", 32'(digit_an), 32'hF);

    // 3: last load wins; load on the boundary bypasses pending
    wait_pos(30);  do_load(7'h01, 7'h02, 7'h03, 7'h04, 1'b0);
    wait_pos(100); do_load(7'h11, 7'h12, 7'h13, 7'h14, 1'b0);
    wait_pos(9);   check("t3_b_seg", 32'(seg_out), 32'h11);
    wait_pos(0);   do_load(7'h21, 7'h22, 7'h23, 7'h24, 1'b0);
    wait_pos(9);   check("t3_c_seg", 32'(seg_out), 32'h21);
                   check("t3_c_an", 32'(digit_an), 32'hE);
    brightness = 4'd15;

    // 4: drop LED turns on at the boundary and blinks every two frames
    wait_pos(20);  do_load(7'h21, 7'h22, 7'h23, 7'h24, 1'b1);
    wait_pos(0);   check("t4_led_pre", 32'(drop_led), 32'h0);
    wait_pos(1);   check("t4_led_on", 32'(drop_led), 32'h1);
    wait_pos(1);   check("t4_led_k1", 32'(drop_led), 32'h1);
    wait_pos(0);   check("t4_led_k2pre", 32'(drop_led), 32'h1);
    wait_pos(1);   check("t4_led_k2", 32'(drop_led), 32'h0);
    wait_pos(1);   check("t4_led_k3", 32'(drop_led), 32'h0);
    wait_pos(1);   check("t4_led_k4", 32'(drop_led), 32'h1);
    wait_pos(20);  do_load(7'h21, 7'h22, 7'h23, 7'h24, 1'b0);
    wait_pos(1);   check("t4_led_clr", 32'(drop_led), 32'h0);

    // 5: async reset in the middle of digit 2's on-window
    wait_pos(20);  do_load(7'h3F, 7'h06, 7'h5B, 7'h4F, 1'b1);
    wait_pos(0);
    wait_pos(100); check("t5_pre_an", 32'(digit_an), 32'hB);
                   check("t5_pre_led", 32'(drop_led), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_an", 32'(digit_an), 32'hF);
    check("t5_rst_seg", 32'(seg_out), 32'h0);
    check("t5_rst_led", 32'(drop_led), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_pos(9);   check("t5_idle_an", 32'(digit_an), 32'hF);
    wait_pos(89);  check("t5_idle_d2", 32'(digit_an), 32'hF);
    wait_pos(0);   do_load(7'h3F, 7'h06, 7'h5B, 7'h4F, 1'b0);
    wait_pos(9);   check("t5_restart_an", 32'(digit_an), 32'hE);
                   check("t5_restart_seg", 32'(seg_out), 32'h3F);

    // 6: random loads and brightness
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 39) == 0);
      if (load) begin
        seg_in1 = 7'($urandom); seg_in2 = 7'($urandom);
        seg_in3 = 7'($urandom); seg_in4 = 7'($urandom);
        drop_in = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 199) == 0) brightness = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
